// File: rtl/radix4_booth_seq_mult.sv
// Sequential radix-4 Booth multiplier for unsigned operands, one digit per cycle.
// Exact or approximate (low-column truncated partial products) mode per operand pair.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake (a, b, mode sampled on accept)
//   out_valid/out_ready   product handshake (p, p_mode held until taken)
//   busy                  high while a product is being computed or waiting
`timescale 1ns/1ps
module radix4_booth_seq_mult #(
    parameter int WIDTH       = 32,
    parameter int APPROX_COLS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 p_mode,
    output logic                 busy
);
    localparam int AW = 2*WIDTH + 2;
    localparam int BW = WIDTH + 3;
    localparam int ND = WIDTH/2 + 1;
    localparam int CW = $clog2(ND);
    localparam logic [CW-1:0] LAST = CW'(ND - 1);
    localparam logic [AW-1:0] APPROX_MASK =
        ~((AW'(1) << APPROX_COLS) - AW'(1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        mcand_q, mcand_d;
    logic [BW-1:0]        mplier_q, mplier_d;
    logic                 mode_q, mode_d;
    logic [AW-1:0]        acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 p_mode_q, p_mode_d;

    logic [AW-1:0]        pp;
    logic [AW-1:0]        pp_m;
    logic [AW-1:0]        acc_sum;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        p_mode_d = p_mode_q;

        // mplier_q[2:0] = {b[2i+1], b[2i], b[2i-1]}; mcand_q = a * 4^i
        unique case (mplier_q[2:0])
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
        endcase

        pp_m    = mode_q ? (pp & APPROX_MASK) : pp;
        acc_sum = acc_q + pp_m;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{(AW-WIDTH){1'b0}}, a};
                    // zero-extended by two bits, with b[-1] = 0 appended
                    mplier_d = {2'b00, b, 1'b0};
                    mode_d   = mode;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 2;
                mplier_d = mplier_q >> 2;
                if (cnt_q == LAST) begin
                    p_d      = acc_sum[2*WIDTH-1:0];
                    p_mode_d = mode_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            p_mode_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            p_mode_q <= p_mode_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign p         = p_q;
    assign p_mode    = p_mode_q;

endmodule
